// File: rtl/mark_period_meter.sv
// Mark-to-mark period meter: per-channel period, max period, timeout and
// saturation tracking, with counting driven by an asynchronous 1 us time-base.
module mark_period_meter #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk1us,
  input  logic [N_CH-1:0]         mark,
  input  logic                    clr_max,
  input  logic [CNT_W-1:0]        timeout_lim,
  output logic [N_CH*CNT_W-1:0]   period,
  output logic [N_CH*CNT_W-1:0]   period_max,
  output logic [N_CH-1:0]         period_vld,
  output logic [N_CH-1:0]         timeout,
  output logic [N_CH-1:0]         sat
);

  localparam int unsigned SW = N_CH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  logic [1:0]    rst_sync_q;
  logic          rst_n_int;
  logic [SW-1:0] raw_in;
  logic [SW-1:0] s1_q, s2_q, hist_q, p1_q, p2_q;
  logic          tick_ev;
  logic [N_CH-1:0] mark_ev;

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] per_q [N_CH];
  logic [CNT_W-1:0] per_d [N_CH];
  logic [CNT_W-1:0] max_q [N_CH];
  logic [CNT_W-1:0] max_d [N_CH];
  logic [N_CH-1:0]  armed_q, armed_d;
  logic [N_CH-1:0]  vld_q, vld_d;
  logic [N_CH-1:0]  to_q, to_d;
  logic [N_CH-1:0]  sat_q, sat_d;

  // Reset asserts asynchronously, releases on the second clk edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];
  assign raw_in    = {mark, clk1us};

  // Synchronise tick and marks, detect rising edges, then delay two stages so
  // the period update lands exactly 4 clocks after the first high sample.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hist_q <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
    end else begin
      s1_q   <= raw_in;
      s2_q   <= s1_q;
      hist_q <= s2_q;
      p1_q   <= s2_q & ~hist_q;
      p2_q   <= p1_q;
    end
  end

  assign tick_ev = p2_q[0];
  assign mark_ev = p2_q[SW-1:1];

  // Per-channel counter, period capture, max tracking, timeout and saturation.
  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    max_d   = max_q;
    armed_d = armed_q;
    vld_d   = '0;
    to_d    = to_q;
    sat_d   = sat_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (clr_max) begin
        max_d[i] = '0;
        sat_d[i] = 1'b0;
      end
      if (mark_ev[i]) begin
        // A mark always restarts the count; a coincident tick is dropped.
        cnt_d[i]   = '0;
        armed_d[i] = 1'b1;
        if (armed_q[i]) begin
          per_d[i] = cnt_q[i];
          vld_d[i] = 1'b1;
          to_d[i]  = 1'b0;
          if (cnt_q[i] > max_d[i]) max_d[i] = cnt_q[i];
        end
      end else begin
        if (tick_ev && (cnt_q[i] != CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
          if (cnt_q[i] == CNT_PRE) sat_d[i] = 1'b1;
        end
        if (armed_q[i] && (timeout_lim != '0) && (cnt_q[i] == timeout_lim))
          to_d[i] = 1'b1;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        per_q[i] <= '0;
        max_q[i] <= '0;
      end
      armed_q <= '0;
      vld_q   <= '0;
      to_q    <= '0;
      sat_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      max_q   <= max_d;
      armed_q <= armed_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      sat_q   <= sat_d;
    end
  end

  // Pack registered channel fields onto the flat output buses.
  always_comb begin
    period     = '0;
    period_max = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      period[i*CNT_W +: CNT_W]     = per_q[i];
      period_max[i*CNT_W +: CNT_W] = max_q[i];
    end
  end

  assign period_vld = vld_q;
  assign timeout    = to_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_mark_period_meter.sv
// Directed bench for mark_period_meter: a 32-bit instance for period, max,
// timeout, coincidence and reset, plus an 8-bit instance for saturation.
// One time-base tick is 6 clk cycles (3 high, 3 low).
module tb_mark_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clk1us;
  logic [1:0]  mark;
  logic        clr_max;
  logic [31:0] lim_a;
  logic [7:0]  lim_b;

  logic [63:0] per_a, max_a;
  logic [1:0]  vld_a, to_a, sat_a;
  logic [15:0] per_b, max_b;
  logic [1:0]  vld_b, to_b, sat_b;

  int checks = 0;
  int errors = 0;
  logic [1:0] v_pre, v_at, v_post;

  mark_period_meter #(.N_CH(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .clk1us(clk1us), .mark(mark), .clr_max(clr_max),
    .timeout_lim(lim_a), .period(per_a), .period_max(max_a),
    .period_vld(vld_a), .timeout(to_a), .sat(sat_a)
  );

  mark_period_meter #(.N_CH(2), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .clk1us(clk1us), .mark(mark), .clr_max(clr_max),
    .timeout_lim(lim_b), .period(per_b), .period_max(max_b),
    .period_vld(vld_b), .timeout(to_b), .sat(sat_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      clk1us = 1'b1;
      repeat (3) @(negedge clk);
      clk1us = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  // Raise mark bits (optionally with a tick on the same clock) and sample
  // period_vld 4, 5 and 6 clocks after the first sampling edge.
  task automatic pulse(input logic [1:0] m, input logic t);
    mark   = m;
    clk1us = t;
    repeat (3) @(negedge clk);
    clk1us = 1'b0;
    @(negedge clk); v_pre  = vld_a;
    @(negedge clk); v_at   = vld_a;
    @(negedge clk); v_post = vld_a;
    mark = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_max();
    clr_max = 1'b1;
    @(negedge clk);
    clr_max = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; clk1us = 1'b0; mark = 2'b00; clr_max = 1'b0;
    lim_a = 32'd0; lim_b = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_period",  per_a, 64'd0);
    chk("rst_max",     max_a, 64'd0);
    chk("rst_vld",     {62'd0, vld_a}, 64'd0);
    chk("rst_timeout", {62'd0, to_a}, 64'd0);
    chk("rst_sat",     {62'd0, sat_a}, 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Basic period: arm, then two 1000-tick periods
    pulse(2'b01, 1'b0);
    chk("arm_no_vld", {62'd0, v_at}, 64'd0);
    chk("arm_period", per_a, 64'd0);
    tick(1000);
    pulse(2'b01, 1'b0);
    chk("p1_vld_pre",  {62'd0, v_pre}, 64'd0);
    chk("p1_vld_at",   {62'd0, v_at}, 64'd1);
    chk("p1_vld_post", {62'd0, v_post}, 64'd0);
    chk("p1_period",   per_a, {32'd0, 32'd1000});
    tick(1000);
    pulse(2'b01, 1'b0);
    chk("p2_vld_at",   {62'd0, v_at}, 64'd1);
    chk("p2_period",   per_a, {32'd0, 32'd1000});
    chk("p2_max",      max_a, {32'd0, 32'd1000});

    // Max tracking and clear
    clear_max();
    chk("clr1_max", max_a, 64'd0);
    tick(500);  pulse(2'b01, 1'b0);
    chk("m500_max", max_a, {32'd0, 32'd500});
    tick(1200); pulse(2'b01, 1'b0);
    chk("m1200_max", max_a, {32'd0, 32'd1200});
    tick(800);  pulse(2'b01, 1'b0);
    chk("m800_period", per_a, {32'd0, 32'd800});
    chk("m800_max",    max_a, {32'd0, 32'd1200});
    clear_max();
    chk("clr2_max",    max_a, 64'd0);
    chk("clr2_period", per_a, {32'd0, 32'd800});
    tick(300);  pulse(2'b01, 1'b0);
    chk("m300_max", max_a, {32'd0, 32'd300});

    // Timeout at 100 ticks; unarmed channel 1 never times out
    lim_a = 32'd100;
    tick(99);
    chk("to_99",  {62'd0, to_a}, 64'd0);
    tick(1);
    chk("to_100", {62'd0, to_a}, 64'd1);
    tick(50);
    chk("to_150", {62'd0, to_a}, 64'd1);
    pulse(2'b01, 1'b0);
    chk("to_vld",    {62'd0, v_at}, 64'd1);
    chk("to_period", per_a, {32'd0, 32'd150});
    chk("to_clear",  {62'd0, to_a}, 64'd0);
    chk("to_max",    max_a, {32'd0, 32'd300});
    lim_a = 32'd0;

    // Coincident tick is dropped; both channels update together
    tick(7);
    pulse(2'b11, 1'b1);
    chk("co_vld",    {62'd0, v_at}, 64'd1);
    chk("co_period", per_a, {32'd0, 32'd7});
    tick(20);
    pulse(2'b11, 1'b0);
    chk("both_vld",    {62'd0, v_at}, 64'd3);
    chk("both_period", per_a, {32'd20, 32'd20});
    chk("both_max",    max_a, {32'd20, 32'd300});

    // Saturation on the 8-bit instance
    clear_max();
    chk("sat_clr", {62'd0, sat_b}, 64'd0);
    pulse(2'b01, 1'b0);
    tick(254);
    chk("sat_254", {62'd0, sat_b}, 64'd0);
    tick(1);
    chk("sat_255", {62'd0, sat_b}, 64'd3);
    tick(45);
    pulse(2'b01, 1'b0);
    chk("sat_period8", {48'd0, per_b[7:0]}, 64'd255);
    chk("sat_sticky",  {62'd0, sat_b}, 64'd3);
    chk("sat_period32", per_a, {32'd20, 32'd300});
    chk("sat_none32",  {62'd0, sat_a}, 64'd0);
    clear_max();
    chk("sat_cleared", {62'd0, sat_b}, 64'd0);
    chk("sat_max32",   max_a, 64'd0);
    tick(10); pulse(2'b01, 1'b0);
    tick(300); pulse(2'b01, 1'b0);
    chk("pre_rst_max", max_a, {32'd0, 32'd300});

    // Reset mid-period
    tick(400);
    rst = 1'b0;
    #1;
    chk("mid_rst_period",  per_a, 64'd0);
    chk("mid_rst_max",     max_a, 64'd0);
    chk("mid_rst_vld",     {62'd0, vld_a}, 64'd0);
    chk("mid_rst_timeout", {62'd0, to_a}, 64'd0);
    chk("mid_rst_sat",     {62'd0, sat_a}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    pulse(2'b01, 1'b0);
    chk("rearm_no_vld", {62'd0, v_at}, 64'd0);
    chk("rearm_period", per_a, 64'd0);
    tick(10);
    pulse(2'b01, 1'b0);
    chk("post_rst_vld",    {62'd0, v_at}, 64'd1);
    chk("post_rst_period", per_a, {32'd0, 32'd10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
